// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: arbitrates two valid/ready requesters onto one ALU, registers the result and owns the CNZV flags
module alu_issue_ctrl #(
    parameter int          WORD_WIDTH  = 32,
    parameter logic [3:0]  FLAGS_RESET = 4'b0000
) (
    input  logic                  in_Clock,
    input  logic                  in_Reset_n,
    input  logic [1:0]            in_Req_valid,
    output logic [1:0]            out_Req_ready,
    input  logic [WORD_WIDTH-1:0] in_Rn0,
    input  logic [WORD_WIDTH-1:0] in_Rn1,
    input  logic [WORD_WIDTH-1:0] in_Op2_0,
    input  logic [WORD_WIDTH-1:0] in_Op2_1,
    input  logic [1:0]            in_Bc,
    input  logic [3:0]            in_Opcode0,
    input  logic [3:0]            in_Opcode1,
    input  logic [1:0]            in_Set_cond,
    output logic [1:0]            out_Resp_valid,
    input  logic [1:0]            in_Resp_ready,
    output logic [WORD_WIDTH-1:0] out_Result,
    output logic [3:0]            out_Resp_CNZV,
    input  logic                  in_Flag_we,
    input  logic [3:0]            in_Flag_wdata,
    output logic [3:0]            out_CNZV,
    output logic [WORD_WIDTH-1:0] alu_Rn,
    output logic [WORD_WIDTH-1:0] alu_Op2,
    output logic                  alu_Barrel_carry,
    output logic [3:0]            alu_Opcode,
    output logic [3:0]            alu_CNZV,
    output logic                  alu_Set_cond,
    input  logic [WORD_WIDTH-1:0] alu_Y,
    input  logic [3:0]            alu_CNZV_out
);
    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
    state_t state, state_nxt;
    logic rr_ptr, gid, sel, set_cond_q;
    always_comb begin
        out_Req_ready = 2'b00;
        state_nxt = state;
        if (state == IDLE) begin
            out_Req_ready = &in_Req_valid ? (rr_ptr ? 2'b10 : 2'b01) : in_Req_valid;
            state_nxt = |in_Req_valid ? EXEC : IDLE;
        end else begin
            state_nxt = state == EXEC ? HOLD : (in_Resp_ready[gid] ? IDLE : HOLD);
        end
    end
    assign sel = out_Req_ready[1];
    assign alu_CNZV = out_CNZV;
    assign alu_Set_cond = set_cond_q;
    always_ff @(posedge in_Clock or negedge in_Reset_n) begin
        if (!in_Reset_n) begin
            state            <= IDLE;
            rr_ptr           <= 1'b0;
            gid              <= 1'b0;
            set_cond_q       <= 1'b0;
            alu_Rn           <= '0;
            alu_Op2          <= '0;
            alu_Barrel_carry <= 1'b0;
            alu_Opcode       <= 4'd0;
            out_Resp_valid   <= 2'b00;
            out_Result       <= '0;
            out_Resp_CNZV    <= 4'd0;
            out_CNZV         <= FLAGS_RESET;
        end else begin
            state <= state_nxt;
            if (|out_Req_ready) begin
                gid              <= sel;
                set_cond_q       <= sel ? in_Set_cond[1] : in_Set_cond[0];
                alu_Rn           <= sel ? in_Rn1 : in_Rn0;
                alu_Op2          <= sel ? in_Op2_1 : in_Op2_0;
                alu_Barrel_carry <= sel ? in_Bc[1] : in_Bc[0];
                alu_Opcode       <= sel ? in_Opcode1 : in_Opcode0;
                if (&in_Req_valid)
                    rr_ptr <= ~sel;
            end
            if (state == EXEC) begin
                out_Result     <= alu_Y;
                out_Resp_CNZV  <= alu_CNZV_out;
                out_Resp_valid <= gid ? 2'b10 : 2'b01;
            end
            if (state == HOLD && in_Resp_ready[gid])
                out_Resp_valid <= 2'b00;
            // an external flag write overrides a same-cycle ALU flag update
            if (in_Flag_we)
                out_CNZV <= in_Flag_wdata;
            else if (state == EXEC && set_cond_q)
                out_CNZV <= alu_CNZV_out;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vectors, corner sequences and randomized model check of alu_issue_ctrl
module tb_alu_issue_ctrl;
    localparam int W = 32;
    logic clk = 0, rst_n = 0;
    logic [1:0] req_valid = 0, req_ready, resp_valid, resp_ready = 0, bc = 0, set_cond = 0;
    logic [W-1:0] rn0 = 0, rn1 = 0, op2_0 = 0, op2_1 = 0, result;
    logic [3:0] opc0 = 0, opc1 = 0, resp_cnzv, cnzv, flag_wdata = 0;
    logic flag_we = 0;
    logic [W-1:0] alu_rn, alu_op2, alu_y;
    logic alu_bc, alu_sc;
    logic [3:0] alu_opc, alu_cin, alu_cout;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WORD_WIDTH(W), .FLAGS_RESET(4'b0000)) dut (
        .in_Clock(clk), .in_Reset_n(rst_n), .in_Req_valid(req_valid), .out_Req_ready(req_ready),
        .in_Rn0(rn0), .in_Rn1(rn1), .in_Op2_0(op2_0), .in_Op2_1(op2_1), .in_Bc(bc),
        .in_Opcode0(opc0), .in_Opcode1(opc1), .in_Set_cond(set_cond), .out_Resp_valid(resp_valid),
        .in_Resp_ready(resp_ready), .out_Result(result), .out_Resp_CNZV(resp_cnzv),
        .in_Flag_we(flag_we), .in_Flag_wdata(flag_wdata), .out_CNZV(cnzv),
        .alu_Rn(alu_rn), .alu_Op2(alu_op2), .alu_Barrel_carry(alu_bc), .alu_Opcode(alu_opc),
        .alu_CNZV(alu_cin), .alu_Set_cond(alu_sc), .alu_Y(alu_y), .alu_CNZV_out(alu_cout));

    // ALU stand-in: 0 AND, 1 EOR, 2 SUB, 3 RSB, 4 ADD, 5 ADC, others MOV Op2
    function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a, b,
                                           input logic bcv, input logic [3:0] f);
        logic [32:0] s;
        logic [31:0] y;
        logic c, v;
        s = '0; y = b; c = bcv; v = f[0];
        case (op)
            4'd0: y = a & b;
            4'd1: y = a ^ b;
            4'd2: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; y = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (y[31] != a[31]); end
            4'd3: begin s = {1'b0, b} + {1'b0, ~a} + 33'd1; y = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (y[31] != b[31]); end
            4'd4: begin s = {1'b0, a} + {1'b0, b}; y = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (y[31] != a[31]); end
            4'd5: begin s = {1'b0, a} + {1'b0, b} + {32'd0, f[3]}; y = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (y[31] != a[31]); end
            default: ;
        endcase
        return {c, y[31], y == 32'd0, v, y};
    endfunction

    always_comb {alu_cout, alu_y} = alu_fn(alu_opc, alu_rn, alu_op2, alu_bc, alu_cin);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input int r, input logic [3:0] op, input logic [W-1:0] a, b,
                         input logic bcv, sc, input logic [W-1:0] ey, input logic [3:0] ef, eflags);
        int n;
        logic [1:0] m;
        n = 0;
        m = (r == 0) ? 2'b01 : 2'b10;
        if (r == 0) begin rn0 = a; op2_0 = b; opc0 = op; end
        else begin rn1 = a; op2_1 = b; opc1 = op; end
        bc[r] = bcv; set_cond[r] = sc; req_valid = m;
        #1;
        while (req_ready !== m && n < 10) begin tick(); n++; end
        chk("req_ready", req_ready, m);
        tick();
        req_valid = 0;
        #1;
        chk("exec_no_resp", resp_valid, 0);
        tick();
        chk("resp_valid", resp_valid, m);
        chk("result", result, ey);
        chk("resp_cnzv", resp_cnzv, ef);
        chk("cnzv", cnzv, eflags);
        resp_ready = m;
        tick();
        resp_ready = 0;
        #1;
        chk("resp_clear", resp_valid, 0);
    endtask

    typedef struct {
        int r; logic [3:0] op; logic [W-1:0] a, b; logic bcv, sc;
        logic [W-1:0] ey; logic [3:0] ef, eflags;
    } vec_t;
    vec_t vt[8];

    typedef struct {logic [3:0] op; logic [W-1:0] a, b; logic bcv, sc;} txn_t;

    initial begin
        txn_t cur;
        logic [1:0] exp_ready, gm;
        logic [35:0] rr;
        logic [W-1:0] m_res;
        logic [3:0] m_rf, m_fl, nf;
        logic m_rr, m_gid;
        int stage;
        vt[0] = '{0, 4'd4, 32'd2, 32'd3, 1'b0, 1'b1, 32'd5, 4'b0000, 4'b0000};
        vt[1] = '{1, 4'd2, 32'd1, 32'd1, 1'b0, 1'b1, 32'd0, 4'b1010, 4'b1010};
        vt[2] = '{0, 4'd4, 32'h7fffffff, 32'd1, 1'b0, 1'b0, 32'h80000000, 4'b0101, 4'b1010};
        vt[3] = '{1, 4'd5, 32'd1, 32'd1, 1'b0, 1'b1, 32'd3, 4'b0000, 4'b0000};
        vt[4] = '{0, 4'd2, 32'd0, 32'd1, 1'b0, 1'b1, 32'hffffffff, 4'b0100, 4'b0100};
        vt[5] = '{1, 4'd0, 32'hf0, 32'h0f, 1'b1, 1'b1, 32'd0, 4'b1010, 4'b1010};
        vt[6] = '{0, 4'd1, 32'hff, 32'h0f, 1'b0, 1'b1, 32'hf0, 4'b0000, 4'b0000};
        vt[7] = '{1, 4'd3, 32'd3, 32'd5, 1'b0, 1'b0, 32'd2, 4'b1000, 4'b0000};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_resp_cnzv", resp_cnzv, 0);
        chk("rst_cnzv", cnzv, 0);
        @(negedge clk) rst_n = 1;
        tick();
        for (int i = 0; i < 8; i++)
            do_op(vt[i].r, vt[i].op, vt[i].a, vt[i].b, vt[i].bcv, vt[i].sc, vt[i].ey, vt[i].ef, vt[i].eflags);
        do_op(1, 4'd2, 1, 1, 0, 1, 0, 4'b1010, 4'b1010);
        flag_we = 1; flag_wdata = 4'b0000;
        tick();
        flag_we = 0;
        chk("flag_clear", cnzv, 4'b0000);
        do_op(1, 4'd2, 1, 1, 0, 0, 0, 4'b1010, 4'b0000);

        // both requesters valid continuously alternate from rr_ptr=0
        rst_n = 0; #2; rst_n = 1;
        tick();
        rn0 = 10; op2_0 = 1; opc0 = 4'd4; rn1 = 20; op2_1 = 2; opc1 = 4'd4; set_cond = 0; bc = 0;
        req_valid = 2'b11; resp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            gm = (k % 2 == 1) ? 2'b10 : 2'b01;
            #1;
            chk("rr_grant", req_ready, gm);
            tick();
            tick();
            chk("rr_resp_valid", resp_valid, gm);
            chk("rr_result", result, gm == 2'b01 ? 32'd11 : 32'd22);
            tick();
        end
        req_valid = 0; resp_ready = 0;

        // backpressure on requester 0 blocks requester 1
        req_valid = 2'b01;
        #1;
        chk("bp_grant0", req_ready, 2'b01);
        tick();
        req_valid = 2'b10; resp_ready = 2'b10;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", resp_valid, 2'b01);
            chk("bp_result", result, 11);
            chk("bp_no_grant", req_ready, 2'b00);
            tick();
        end
        resp_ready = 2'b01;
        tick();
        resp_ready = 0;
        #1;
        chk("bp_release", resp_valid, 0);
        chk("bp_grant1", req_ready, 2'b10);
        tick();
        req_valid = 0;
        tick();
        chk("bp_resp1", resp_valid, 2'b10);
        chk("bp_result1", result, 22);
        resp_ready = 2'b10;
        tick();
        resp_ready = 0;

        // external flag write wins over the ALU update on the same edge
        rn0 = 2; op2_0 = 3; opc0 = 4'd4; set_cond = 2'b01; req_valid = 2'b01;
        #1;
        chk("fw_grant", req_ready, 2'b01);
        tick();
        req_valid = 0; flag_we = 1; flag_wdata = 4'b0110;
        tick();
        flag_we = 0;
        chk("fw_cnzv", cnzv, 4'b0110);
        chk("fw_resp_cnzv", resp_cnzv, 4'b0000);
        chk("fw_resp_valid", resp_valid, 2'b01);
        resp_ready = 2'b01;
        tick();
        resp_ready = 0;

        // async reset while holding a response
        rn0 = 32'h7fffffff; op2_0 = 1; req_valid = 2'b01;
        tick();
        req_valid = 0;
        tick();
        tick();
        chk("hold_before_rst", resp_valid, 2'b01);
        #2;
        rst_n = 0;
        #1;
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_result", result, 0);
        chk("arst_resp_cnzv", resp_cnzv, 0);
        chk("arst_cnzv", cnzv, 0);
        @(negedge clk) rst_n = 1;
        tick();
        do_op(0, 4'd4, 2, 3, 0, 1, 5, 4'b0000, 4'b0000);

        // randomized run against a transaction-level model
        req_valid = 0; set_cond = 0; flag_we = 0; resp_ready = 0;
        rst_n = 0; #2; rst_n = 1; #1;
        stage = 0; m_rr = 0; m_gid = 0; m_fl = 4'b0000; m_res = 0; m_rf = 0;
        cur = '{4'd0, '0, '0, 1'b0, 1'b0};
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++)
                if (!req_valid[i] && $urandom_range(2) == 0) begin
                    if (i == 0) begin
                        rn0 = $urandom_range(3) == 0 ? W'($urandom_range(3)) : W'($urandom);
                        op2_0 = $urandom_range(3) == 0 ? W'($urandom_range(3)) : W'($urandom);
                        opc0 = 4'($urandom_range(7));
                    end else begin
                        rn1 = $urandom_range(3) == 0 ? W'($urandom_range(3)) : W'($urandom);
                        op2_1 = $urandom_range(3) == 0 ? W'($urandom_range(3)) : W'($urandom);
                        opc1 = 4'($urandom_range(7));
                    end
                    bc[i] = 1'($urandom); set_cond[i] = 1'($urandom); req_valid[i] = 1;
                end
            resp_ready = 2'($urandom);
            flag_we = $urandom_range(9) == 0;
            flag_wdata = 4'($urandom);
            #1;
            exp_ready = stage != 0 ? 2'b00 : (&req_valid ? (m_rr ? 2'b10 : 2'b01) : req_valid);
            chk("rnd_ready", req_ready, exp_ready);
            chk("rnd_resp_valid", resp_valid, stage == 2 ? (m_gid ? 2'b10 : 2'b01) : 2'b00);
            chk("rnd_cnzv", cnzv, m_fl);
            if (stage == 2) begin
                chk("rnd_result", result, m_res);
                chk("rnd_resp_cnzv", resp_cnzv, m_rf);
            end
            tick();
            nf = m_fl;
            if (stage == 1) begin
                rr = alu_fn(cur.op, cur.a, cur.b, cur.bcv, m_fl);
                m_res = rr[31:0]; m_rf = rr[35:32];
                if (cur.sc) nf = m_rf;
                stage = 2;
            end else if (stage == 2) begin
                if (resp_ready[m_gid]) stage = 0;
            end else if (|exp_ready) begin
                m_gid = exp_ready[1];
                cur = m_gid ? '{opc1, rn1, op2_1, bc[1], set_cond[1]} : '{opc0, rn0, op2_0, bc[0], set_cond[0]};
                if (&req_valid) m_rr = ~m_gid;
                req_valid[m_gid] = 0;
                stage = 1;
            end
            if (flag_we) nf = flag_wdata;
            m_fl = nf;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
